// File: rtl/codec_config_sequencer.sv
// Codec configuration sequencer: walks a constant table of {register, data}
// pairs and issues each one as an I2C write, with per-entry retry on NACK
// or timeout, a fixed idle gap between writes, and held done/fail status.
module codec_config_sequencer #(
    parameter int unsigned NUM_REGS       = 8,
    parameter logic [6:0]  SLAVE_ADDR     = 7'h1A,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [6:0] slav_addr,
    output logic       read_not_write,
    output logic [7:0] reg_addr,
    output logic [7:0] write_data,
    output logic       write_valid,
    input  logic       write_ready,
    input  logic       error,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] index
);

    localparam int unsigned IDX_W = (NUM_REGS > 1)       ? $clog2(NUM_REGS)       : 1;
    localparam int unsigned ATT_W = (MAX_ATTEMPTS > 1)   ? $clog2(MAX_ATTEMPTS)   : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1)     ? $clog2(GAP_CYCLES)     : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [ATT_W-1:0] LAST_ATT = ATT_W'(MAX_ATTEMPTS - 1);
    localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        GAP,
        DONE,
        FAIL
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx_q;
    logic [ATT_W-1:0] att_q;
    logic [TMO_W-1:0] tmo_q;
    logic [GAP_W-1:0] gap_q;

    logic             tmo_last;
    logic             xfer_end;
    logic             xfer_ok;
    logic [IDX_W-1:0] nxt_idx;

    // Configuration table, {reg_addr, write_data}; unused slots write zero.
    function automatic logic [15:0] rom_entry(input logic [IDX_W-1:0] i);
        case (int'(i))
            0:       rom_entry = 16'h1E00;
            1:       rom_entry = 16'h0C00;
            2:       rom_entry = 16'h0814;
            3:       rom_entry = 16'h0A00;
            4:       rom_entry = 16'h0E42;
            5:       rom_entry = 16'h1000;
            6:       rom_entry = 16'h0017;
            7:       rom_entry = 16'h1201;
            default: rom_entry = 16'h0000;
        endcase
    endfunction

    assign slav_addr      = SLAVE_ADDR;
    assign read_not_write = 1'b0;
    assign index          = 4'(idx_q);

    // Transaction outcome: first ready in WAIT_DONE completes; timeout counts as a NACK.
    always_comb begin
        tmo_last = (tmo_q == LAST_TMO);
        xfer_end = ((state == WAIT_BUSY) && tmo_last) ||
                   ((state == WAIT_DONE) && (write_ready || tmo_last));
        xfer_ok  = (state == WAIT_DONE) && write_ready && !error;
        nxt_idx  = xfer_ok ? idx_q + 1'b1 : idx_q;
    end

    // Sequencer FSM with registered status and bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx_q       <= '0;
            att_q       <= '0;
            tmo_q       <= '0;
            gap_q       <= '0;
            write_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            reg_addr    <= '0;
            write_data  <= '0;
        end else begin
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        state                  <= SEND;
                        idx_q                  <= '0;
                        att_q                  <= '0;
                        write_valid            <= 1'b1;
                        busy                   <= 1'b1;
                        done                   <= 1'b0;
                        fail                   <= 1'b0;
                        {reg_addr, write_data} <= rom_entry('0);
                    end
                end
                SEND: begin
                    if (write_ready) begin
                        state       <= WAIT_BUSY;
                        write_valid <= 1'b0;
                        tmo_q       <= '0;
                    end
                end
                WAIT_BUSY, WAIT_DONE: begin
                    if (xfer_end) begin
                        if (xfer_ok && (idx_q == LAST_IDX)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (!xfer_ok && (att_q == LAST_ATT)) begin
                            state <= FAIL;
                            busy  <= 1'b0;
                            fail  <= 1'b1;
                        end else begin
                            idx_q <= nxt_idx;
                            att_q <= xfer_ok ? '0 : att_q + 1'b1;
                            if (GAP_CYCLES == 0) begin
                                state                  <= SEND;
                                write_valid            <= 1'b1;
                                {reg_addr, write_data} <= rom_entry(nxt_idx);
                            end else begin
                                state <= GAP;
                                gap_q <= '0;
                            end
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if ((state == WAIT_BUSY) && !write_ready) begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == LAST_GAP) begin
                        state                  <= SEND;
                        write_valid            <= 1'b1;
                        {reg_addr, write_data} <= rom_entry(idx_q);
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer with a behavioural I2C master model.
module tb_codec_config_sequencer;

    localparam int LOW_CYCLES = 30;
    localparam logic [15:0] EXP_TBL [8] = '{16'h1E00, 16'h0C00, 16'h0814, 16'h0A00,
                                            16'h0E42, 16'h1000, 16'h0017, 16'h1201};

    logic       clk;
    logic       reset;
    logic       start;
    logic [6:0] slav_addr;
    logic       read_not_write;
    logic [7:0] reg_addr;
    logic [7:0] write_data;
    logic       write_valid;
    logic       write_ready;
    logic       error;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] index;

    int total;
    int bad;
    int cyc;

    // Master model controls and handshake log.
    int         hs_count;
    int         nack_idx;
    int         nack_left;
    bit         hang;
    logic [7:0] log_reg [64];
    logic [7:0] log_dat [64];
    logic [3:0] log_idx [64];
    int         log_cyc [64];

    codec_config_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .slav_addr      (slav_addr),
        .read_not_write (read_not_write),
        .reg_addr       (reg_addr),
        .write_data     (write_data),
        .write_valid    (write_valid),
        .write_ready    (write_ready),
        .error          (error),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .index          (index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // I2C master model: ready drops for LOW_CYCLES after each handshake (or until
    // the next request when hung), then rises with the NACK decision on error.
    initial begin : master_model
        int cnt;
        bit pend;
        bit err_next;
        cnt = 0; pend = 0; err_next = 0;
        write_ready = 1'b1;
        error = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                write_ready = 1'b1; error = 1'b0; cnt = 0; pend = 0;
            end else begin
                if (pend) begin
                    pend = 0; write_ready = 1'b0; error = 1'b0; cnt = LOW_CYCLES;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0 && !hang) begin
                        write_ready = 1'b1; error = err_next;
                    end
                end else if (!write_ready && (!hang || write_valid)) begin
                    write_ready = 1'b1; error = 1'b0;
                end
                if (write_valid && write_ready) begin
                    if (hs_count < 64) begin
                        log_reg[hs_count] = reg_addr;
                        log_dat[hs_count] = write_data;
                        log_idx[hs_count] = index;
                        log_cyc[hs_count] = cyc;
                    end
                    hs_count++;
                    err_next = (int'(index) == nack_idx) && (nack_left > 0);
                    if (err_next) nack_left--;
                    pend = 1;
                end
            end
        end
    end

    task automatic clear_model();
        hs_count = 0; nack_idx = -1; nack_left = 0; hang = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done || fail) begin ok = 1; break; end
        end
    endtask

    task automatic wait_hs(input int n, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (hs_count >= n) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail: got %b want 0", fail); end
        total++; if (write_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", write_valid); end
        total++; if (index !== 4'd0) begin bad++; $display("FAIL reset_index: got %0d want 0", index); end
        total++; if (slav_addr !== 7'h1A) begin bad++; $display("FAIL slave_addr: got %h want 1a", slav_addr); end
        total++; if (read_not_write !== 1'b0) begin bad++; $display("FAIL rnw: got %b want 0", read_not_write); end
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_ack();
        bit ok;
        clear_model();
        pulse_start();
        wait_end(2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL all_ack_end: run did not finish within 2000 cycles"); end
        total++; if (hs_count != 8) begin bad++; $display("FAIL all_ack_count: got %0d want 8", hs_count); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({log_reg[i], log_dat[i]} !== EXP_TBL[i] || log_idx[i] !== 4'(i)) begin
                bad++; $display("FAIL all_ack_pair%0d: got %h/%h idx %0d want %h idx %0d",
                                i, log_reg[i], log_dat[i], log_idx[i], EXP_TBL[i], i);
            end
        end
        for (int i = 1; i < 8; i++) begin
            total++;
            if (log_cyc[i] - log_cyc[i-1] != 36) begin
                bad++; $display("FAIL all_ack_spacing%0d: got %0d want 36", i, log_cyc[i] - log_cyc[i-1]);
            end
        end
        total++;
        if ({done, busy, fail, write_valid} !== 4'b1000 || index !== 4'd7) begin
            bad++; $display("FAIL all_ack_status: got d/b/f/v=%b%b%b%b idx %0d want 1000 idx 7",
                            done, busy, fail, write_valid, index);
        end
    endtask

    task automatic test_nack_once();
        bit ok;
        int seq [9] = '{0, 1, 2, 2, 3, 4, 5, 6, 7};
        clear_model();
        nack_idx = 2; nack_left = 1;
        pulse_start();
        wait_end(2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL nack_once_end: run did not finish"); end
        total++; if (hs_count != 9) begin bad++; $display("FAIL nack_once_count: got %0d want 9", hs_count); end
        for (int i = 0; i < 9; i++) begin
            total++;
            if ({log_reg[i], log_dat[i]} !== EXP_TBL[seq[i]] || log_idx[i] !== 4'(seq[i])) begin
                bad++; $display("FAIL nack_once_pair%0d: got %h/%h idx %0d want %h idx %0d",
                                i, log_reg[i], log_dat[i], log_idx[i], EXP_TBL[seq[i]], seq[i]);
            end
        end
        total++;
        if ({done, busy, fail} !== 3'b100) begin
            bad++; $display("FAIL nack_once_status: got d/b/f=%b%b%b want 100", done, busy, fail);
        end
    endtask

    task automatic test_nack_always();
        bit ok;
        bit saw_valid;
        int seq [6] = '{0, 1, 2, 3, 3, 3};
        clear_model();
        nack_idx = 3; nack_left = 1000;
        pulse_start();
        wait_end(2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL nack_always_end: run did not finish"); end
        total++; if (hs_count != 6) begin bad++; $display("FAIL nack_always_count: got %0d want 6", hs_count); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({log_reg[i], log_dat[i]} !== EXP_TBL[seq[i]] || log_idx[i] !== 4'(seq[i])) begin
                bad++; $display("FAIL nack_always_pair%0d: got %h/%h idx %0d want %h idx %0d",
                                i, log_reg[i], log_dat[i], log_idx[i], EXP_TBL[seq[i]], seq[i]);
            end
        end
        total++;
        if ({done, busy, fail} !== 3'b001 || index !== 4'd3) begin
            bad++; $display("FAIL nack_always_status: got d/b/f=%b%b%b idx %0d want 001 idx 3",
                            done, busy, fail, index);
        end
        saw_valid = 0;
        repeat (50) begin
            @(negedge clk);
            if (write_valid !== 1'b0) saw_valid = 1;
        end
        total++; if (saw_valid) begin bad++; $display("FAIL nack_always_quiet: write_valid rose after fail, want 0"); end
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL nack_always_hold: got fail=%b want 1", fail); end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_model();
        hang = 1;
        pulse_start();
        wait_end(1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL timeout_end: run did not finish"); end
        total++; if (hs_count != 3) begin bad++; $display("FAIL timeout_count: got %0d want 3", hs_count); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({log_reg[i], log_dat[i]} !== EXP_TBL[0] || log_idx[i] !== 4'd0) begin
                bad++; $display("FAIL timeout_pair%0d: got %h/%h idx %0d want %h idx 0",
                                i, log_reg[i], log_dat[i], log_idx[i], EXP_TBL[0]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            total++;
            if (log_cyc[i] - log_cyc[i-1] != 69) begin
                bad++; $display("FAIL timeout_spacing%0d: got %0d want 69", i, log_cyc[i] - log_cyc[i-1]);
            end
        end
        total++;
        if ({done, busy, fail} !== 3'b001 || index !== 4'd0) begin
            bad++; $display("FAIL timeout_status: got d/b/f=%b%b%b idx %0d want 001 idx 0",
                            done, busy, fail, index);
        end
        hang = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_model();
        pulse_start();
        wait_hs(6, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL reset_mid_reach: entry 5 never sent"); end
        repeat (10) @(negedge clk);
        total++;
        if (index !== 4'd5 || busy !== 1'b1 || write_valid !== 1'b0) begin
            bad++; $display("FAIL reset_mid_pre: got idx %0d busy %b valid %b want idx 5 busy 1 valid 0",
                            index, busy, write_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, write_valid, done, fail} !== 4'b0000 || index !== 4'd0) begin
            bad++; $display("FAIL reset_mid_idle: got b/v/d/f=%b%b%b%b idx %0d want 0000 idx 0",
                            busy, write_valid, done, fail, index);
        end
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        clear_model();
        pulse_start();
        wait_end(2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL reset_mid_rerun_end: rerun did not finish"); end
        total++;
        if (hs_count != 8 || {log_reg[0], log_dat[0]} !== 16'h1E00 || log_idx[0] !== 4'd0) begin
            bad++; $display("FAIL reset_mid_rerun: got %0d writes first %h/%h want 8 first 1e/00",
                            hs_count, log_reg[0], log_dat[0]);
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL reset_mid_done: got %b want 1", done); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_model();
        pulse_start();
        wait_hs(2, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_reach: second write never sent"); end
        repeat (5) @(negedge clk);
        pulse_start();
        wait_end(2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_end: run did not finish"); end
        total++; if (hs_count != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", hs_count); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (log_idx[i] !== 4'(i) || {log_reg[i], log_dat[i]} !== EXP_TBL[i]) begin
                bad++; $display("FAIL b2b_order%0d: got idx %0d %h/%h want idx %0d %h",
                                i, log_idx[i], log_reg[i], log_dat[i], i, EXP_TBL[i]);
            end
        end
        @(negedge clk);
        hs_count = 0;
        start = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({done, busy, write_valid} !== 3'b011 || index !== 4'd0 || {reg_addr, write_data} !== 16'h1E00) begin
            bad++; $display("FAIL restart_first: got d/b/v=%b%b%b idx %0d %h/%h want 011 idx 0 1e/00",
                            done, busy, write_valid, index, reg_addr, write_data);
        end
        @(negedge clk); start = 1'b0;
        wait_end(2000, ok);
        total++;
        if (!ok || hs_count != 8 || done !== 1'b1) begin
            bad++; $display("FAIL restart_run: got end %0d writes %0d done %b want 1 8 1", ok, hs_count, done);
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; cyc = 0;
        hs_count = 0; nack_idx = -1; nack_left = 0; hang = 0;
        reset = 1'b1; start = 1'b0;
        test_reset();
        test_all_ack();
        test_nack_once();
        test_nack_always();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/codec_config_sequencer.md
CODEC_CONFIG_SEQUENCER -- requirements
Module: codec_config_sequencer

Interface
REQ-001 Parameter NUM_REGS, default 8: number of register writes in the configuration table.
REQ-002 Parameter SLAVE_ADDR, default 7'h1A: I2C slave address presented for every write.
REQ-003 Parameter GAP_CYCLES, default 4: idle cycles inserted between successful writes.
REQ-004 Parameter MAX_ATTEMPTS, default 3: total tries allowed per table entry before failure.
REQ-005 Parameter TIMEOUT_CYCLES, default 64: maximum cycles waited for one transaction to complete.
REQ-006 clk  in  1  single clock, same 20 kHz domain as the I2C master; one clock, reset is synchronous and active-high.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 start  in  1  one-cycle request to run the table from entry 0.
REQ-009 slav_addr  out  7  constant SLAVE_ADDR.
REQ-010 read_not_write  out  1  constant 0 (write only).
REQ-011 reg_addr  out  8  register byte of current entry.
REQ-012 write_data  out  8  data byte of current entry.
REQ-013 write_valid  out  1  request to I2C master.
REQ-014 write_ready  in  1  I2C master idle/accepting; high only while master is idle.
REQ-015 error  in  1  I2C master NACK flag for the last transaction.
REQ-016 busy  out  1  high from start acceptance until DONE or FAIL.
REQ-017 done  out  1  all entries written; held.
REQ-018 fail  out  1  an entry exhausted MAX_ATTEMPTS; held.
REQ-019 index  out  4  current (or failing) entry number.

Function
REQ-020 Table SHALL be an internal constant ROM of {reg_addr, write_data} pairs; default contents in order: 1E/00, 0C/00, 08/14, 0A/00, 0E/42, 10/00, 00/17, 12/01.
REQ-021 States: IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP, DONE, FAIL; every state has one-cycle minimum residency.
REQ-022 IDLE: start=1 -> SEND next cycle, index=0, attempt=0.
REQ-023 SEND: write_valid=1; reg_addr/write_data SHALL equal table[index] and stay stable until handshake; write_valid & write_ready in same cycle -> WAIT_BUSY.
REQ-024 write_valid SHALL be 0 in every state other than SEND.
REQ-025 WAIT_BUSY: write_ready=0 -> WAIT_DONE.
REQ-026 WAIT_DONE: first cycle with write_ready=1 SHALL be treated as completion; error SHALL be sampled in that same cycle.
REQ-027 Completion with error=0: if index==NUM_REGS-1 -> DONE, else index+1, attempt=0, -> GAP.
REQ-028 Completion with error=1: if attempt==MAX_ATTEMPTS-1 -> FAIL with index unchanged, else attempt+1, -> GAP (same index).
REQ-029 Timeout counter SHALL clear on entering WAIT_BUSY and count in WAIT_BUSY and WAIT_DONE; reaching TIMEOUT_CYCLES SHALL be handled as completion with error=1.
REQ-030 GAP: exactly GAP_CYCLES cycles, then SEND; GAP_CYCLES=0 SHALL go directly to SEND.
REQ-031 busy=1 in SEND, WAIT_BUSY, WAIT_DONE, GAP; done=1 only in DONE; fail=1 only in FAIL; all outputs driven from state/registers, no combinational path from inputs.
REQ-032 start SHALL be ignored while busy=1.
REQ-033 start in DONE or FAIL SHALL clear done/fail and restart from index 0 (-> SEND next cycle).
REQ-034 index, attempt and timeout counters SHALL be sized for their parameters without wrap; index never exceeds NUM_REGS-1.

Reset
REQ-035 reset=1 at a clock edge SHALL force IDLE, index=0, attempt=0, timeout=0; write_valid=0, busy=0, done=0, fail=0 on the following cycle, including mid-transaction.
REQ-036 Outputs slav_addr and read_not_write are constants and unaffected by reset.

Verification
REQ-037 Master model acks all writes (ready low 30 cycles per write), start pulse -> 8 handshakes with pairs 1E/00 ... 12/01 in order, 4-cycle gaps, done=1, busy=0, fail=0.
REQ-038 Model NACKs entry 2 once -> entry 2 (08/14) sent twice, index stays 2 for the retry, run ends done=1.
REQ-039 Model NACKs entry 3 always -> exactly 3 attempts of 0A/00, then fail=1, index=3, write_valid stays 0.
REQ-040 Model holds write_ready=0 permanently after handshake -> after 64 cycles one retry attempt; 3 timeouts -> fail=1, index=0.
REQ-041 reset asserted during WAIT_DONE of entry 5 -> next cycle IDLE, busy=0, write_valid=0; later start -> rerun from 1E/00.
REQ-042 start pulsed while busy -> ignored; start in DONE -> done drops, rerun from index 0.
